fetch_queue: RTL and testbench

- Instruction prefetch stage. Sits between the instruction memory and the decode/control path of the RISC-V core.
- Generates sequential fetch addresses and issues one-outstanding requests to instruction memory.
- Buffers up to DEPTH returned instructions together with their PCs, and presents them to decode over a valid/ready handshake.
- A branch/jump redirect flushes the queue and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch stage: FSM states and queue entry layout.
package fetch_pkg;

   localparam int FETCH_DW    = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_DW-1:0] pc;
      logic [FETCH_DW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, decode handshake and redirect.
interface fetch_queue_if #(
   parameter int DW = 32,
   parameter int CW = 3
);
   logic          redirect_i;
   logic [DW-1:0] redirect_pc_i;
   logic          imem_req_o;
   logic [DW-1:0] imem_addr_o;
   logic          imem_rvalid_i;
   logic [DW-1:0] imem_rdata_i;
   logic          instr_valid_o;
   logic [DW-1:0] instr_o;
   logic [DW-1:0] instr_pc_o;
   logic          instr_ready_i;
   logic [CW-1:0] count_o;

   modport master (
      input  redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous queue of {pc, instr} entries with flush; head holds its last value when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   fetch_entry_t  last_q;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         last_q <= head;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   // last_q keeps the most recently presented head visible once the queue drains
   assign head = (count != '0) ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: sequential fetch with one outstanding request, queued results, redirect flush.
//   state   | meaning
//   IDLE    | no request outstanding
//   WAIT    | one request outstanding, response will be queued
//   DISCARD | one request outstanding, response belongs to a flushed path
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int            DW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [DW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   fetch_queue_if.master fq
);
   localparam int CW = $clog2(DEPTH+1);

   fetch_state_e  state_q, state_d;
   logic [DW-1:0] fetch_pc_q;
   logic [DW-1:0] req_pc_q;
   logic [CW-1:0] count;
   logic [CW:0]   occ_next;
   logic          push, pop, issue, space;
   fetch_entry_t  push_data, head;

   assign push     = (state_q == WAIT) && fq.imem_rvalid_i && !fq.redirect_i;
   assign occ_next = {1'b0, count} + {{CW{1'b0}}, push};
   // pop is left out on purpose so instr_ready_i never reaches imem_req_o
   assign space    = occ_next < (CW+1)'(DEPTH);
   assign issue    = !rst && !fq.redirect_i && space &&
                     ((state_q == IDLE) || ((state_q == WAIT) && fq.imem_rvalid_i));
   assign pop      = (count != '0) && fq.instr_ready_i && !fq.redirect_i;
   assign push_data = '{pc: req_pc_q, instr: fq.imem_rdata_i};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (issue) state_d = WAIT;
         end
         WAIT: begin
            if (fq.redirect_i)         state_d = fq.imem_rvalid_i ? IDLE : DISCARD;
            else if (fq.imem_rvalid_i) state_d = issue ? WAIT : IDLE;
         end
         DISCARD: begin
            if (fq.imem_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (fq.redirect_i) begin
            fetch_pc_q <= fq.redirect_pc_i & ~DW'(INSTR_BYTES-1);
         end else if (issue) begin
            fetch_pc_q <= fetch_pc_q + DW'(INSTR_BYTES);
            req_pc_q   <= fetch_pc_q;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (fq.redirect_i),
      .head      (head),
      .count     (count)
   );

   assign fq.imem_req_o    = issue;
   assign fq.imem_addr_o   = issue ? fetch_pc_q : '0;
   assign fq.instr_valid_o = (count != '0);
   assign fq.instr_o       = head.instr;
   assign fq.instr_pc_o    = head.pc;
   assign fq.count_o       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a transaction-level queue/epoch model with a variable-latency memory.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int          DW       = 32;
   localparam int          DEPTH    = 4;
   localparam int          CW       = $clog2(DEPTH+1);
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_if #(.DW(DW), .CW(CW)) fq ();

   fetch_queue #(.DW(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .fq  (fq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   // expected decode-visible queue; epoch advances on every flush
   ent_t        mq[$];
   logic [31:0] exp_pc;
   int          epoch = 0;

   bit          pend_valid = 0;
   logic [31:0] pend_addr, pend_exp;
   int          pend_epoch, pend_wait;

   bit          ready_k = 0, redir_k = 0, stray_k = 0, redir_on_rv_k = 0;
   logic [31:0] rpc_k = '0;
   int          lat_min = 1, lat_max = 1;

   logic [31:0] req_log[$];
   int          max_count;
   logic [31:0] first_pc;
   bit          first_arm = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] log_at(input int i);
      return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_pc     = RESET_PC;
      epoch++;
      pend_valid = 0;
   endtask

   task automatic drive_and_sample();
      bit rv, live, redir, push, exp_req, pop;
      int qs;
      fq.imem_rvalid_i = 1'b0;
      fq.imem_rdata_i  = $urandom;
      if (pend_valid) begin
         pend_wait--;
         if (pend_wait == 0) begin
            fq.imem_rvalid_i = 1'b1;
            fq.imem_rdata_i  = mem_word(pend_addr);
         end
      end else if (stray_k) begin
         fq.imem_rvalid_i = 1'b1;
      end
      fq.redirect_i    = redir_k || (redir_on_rv_k && fq.imem_rvalid_i && mq.size() != 0);
      if (redir_on_rv_k && fq.redirect_i) redir_on_rv_k = 0;
      fq.redirect_pc_i = rpc_k;
      fq.instr_ready_i = ready_k;

      @(negedge clk);
      rv      = fq.imem_rvalid_i;
      redir   = fq.redirect_i;
      qs      = mq.size();
      live    = rv && pend_valid && (pend_epoch == epoch);
      push    = live && !redir;
      exp_req = (!pend_valid || live) && !redir && (qs + int'(push) < DEPTH);

      check("req",   32'(fq.imem_req_o), 32'(exp_req));
      check("addr",  fq.imem_addr_o, exp_req ? exp_pc : 32'h0);
      check("count", 32'(fq.count_o), 32'(qs));
      check("valid", 32'(fq.instr_valid_o), 32'(qs != 0));
      if (qs != 0) begin
         check("head_pc",    fq.instr_pc_o, mq[0].pc);
         check("head_instr", fq.instr_o,    mq[0].instr);
      end
      if (int'(fq.count_o) > max_count) max_count = int'(fq.count_o);
      if (first_arm && fq.instr_valid_o) begin
         first_pc  = fq.instr_pc_o;
         first_arm = 0;
      end
      if (fq.imem_req_o) req_log.push_back(fq.imem_addr_o);

      pop = (qs != 0) && fq.instr_ready_i;
      if (rv && pend_valid) pend_valid = 0;
      if (redir) begin
         mq.delete();
         exp_pc = fq.redirect_pc_i & ~32'h3;
         epoch++;
      end else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back('{pc: pend_exp, instr: mem_word(pend_exp)});
      end
      if (exp_req) begin
         pend_valid = 1;
         pend_addr  = fq.imem_req_o ? fq.imem_addr_o : exp_pc;
         pend_exp   = exp_pc;
         pend_epoch = epoch;
         pend_wait  = $urandom_range(lat_max, lat_min);
         exp_pc     = exp_pc + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_and_sample();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // asserts reset between edges, checks outputs before any edge, releases just after a posedge
   task automatic hard_reset();
      #2;
      rst = 1'b1;
      fq.redirect_i    = 1'b0;
      fq.imem_rvalid_i = 1'b0;
      #1;
      check("rst_req",   32'(fq.imem_req_o), 32'h0);
      check("rst_addr",  fq.imem_addr_o, 32'h0);
      check("rst_valid", 32'(fq.instr_valid_o), 32'h0);
      check("rst_instr", fq.instr_o, 32'h0);
      check("rst_pc",    fq.instr_pc_o, 32'h0);
      check("rst_count", 32'(fq.count_o), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive_and_sample();
   endtask

   initial begin
      fq.redirect_i    = 1'b0;
      fq.redirect_pc_i = '0;
      fq.imem_rvalid_i = 1'b0;
      fq.imem_rdata_i  = '0;
      fq.instr_ready_i = 1'b0;

      // streaming with 1-cycle memory, decode always ready
      ready_k = 1; lat_min = 1; lat_max = 1;
      req_log.delete(); max_count = 0; first_arm = 1;
      hard_reset();
      run(20);
      check("stream_req0", log_at(0), 32'h0);
      check("stream_req1", log_at(1), 32'h4);
      check("stream_req2", log_at(2), 32'h8);
      check("stream_nreq", 32'(req_log.size()), 32'd21);
      check("stream_max_count_le1", 32'(max_count <= 1), 32'h1);
      check("stream_first_pc", first_pc, 32'h0);

      // fill with decode stalled, then release a single entry
      ready_k = 0;
      req_log.delete();
      hard_reset();
      run(12);
      check("fill_count", 32'(fq.count_o), 32'd4);
      check("fill_req",   32'(fq.imem_req_o), 32'h0);
      check("fill_nreq",  32'(req_log.size()), 32'd4);
      ready_k = 1; step();
      ready_k = 0; step();
      check("fill_head_pc", fq.instr_pc_o, 32'h4);
      check("fill_req4",    log_at(4), 32'h10);

      // redirect with 3 queued and a slow response outstanding
      lat_min = 3; lat_max = 3;
      hard_reset();
      run(10);
      check("pre_redir_count", 32'(fq.count_o), 32'd3);
      redir_k = 1; rpc_k = 32'h0000_0103; step();
      redir_k = 0;
      req_log.delete(); first_arm = 1;
      step();
      check("redir_flush_count", 32'(fq.count_o), 32'h0);
      check("redir_discard_noreq", 32'(fq.imem_req_o), 32'h0);
      ready_k = 1;
      run(12);
      check("redir_first_req", log_at(0), 32'h100);
      check("redir_first_pc",  first_pc, 32'h100);

      // redirect coincident with response and pop
      lat_min = 1; lat_max = 1; ready_k = 0;
      hard_reset();
      run(3);
      ready_k = 1; rpc_k = 32'h0000_0200; redir_on_rv_k = 1;
      step();
      step();
      check("coinc_count", 32'(fq.count_o), 32'h0);
      check("coinc_req",   32'(fq.imem_req_o), 32'h1);
      check("coinc_addr",  fq.imem_addr_o, 32'h200);
      redir_on_rv_k = 0;
      run(5);

      // async reset mid-WAIT with two entries queued, stray rvalid after release
      lat_min = 3; lat_max = 3; ready_k = 0;
      hard_reset();
      run(7);
      check("midwait_count", 32'(fq.count_o), 32'd2);
      req_log.delete();
      stray_k = 1;
      hard_reset();
      stray_k = 0;
      run(6);
      check("post_rst_req0", log_at(0), RESET_PC);
      check("post_rst_req1", log_at(1), RESET_PC + 32'd4);

      // address wrap-around
      lat_min = 1; lat_max = 1; ready_k = 1;
      redir_k = 1; rpc_k = 32'hFFFF_FFF8; step();
      redir_k = 0;
      req_log.delete();
      run(8);
      check("wrap_req0", log_at(0), 32'hFFFF_FFF8);
      check("wrap_req1", log_at(1), 32'hFFFF_FFFC);
      check("wrap_req2", log_at(2), 32'h0000_0000);

      // random traffic
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         ready_k = ($urandom_range(0, 3) != 0);
         redir_k = ($urandom_range(0, 39) == 0);
         rpc_k   = $urandom;
         step();
      end
      redir_k = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
